// File: rtl/sw_pkg.sv
// Shared types, limits and BCD helpers for the lap stopwatch.
// Time is held in binary and converted to BCD only on the display path.
package sw_pkg;

  typedef struct packed {
    logic [5:0] min;
    logic [5:0] sec;
    logic [6:0] cs;
  } time_t;

  localparam logic [6:0] MAX_CS  = 7'd99;
  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam logic [5:0] MAX_MIN = 6'd59;

  // Two-digit binary to BCD; inputs never exceed 99.
  function automatic logic [7:0] bcd2(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 7'd10);
    ones = 4'(v % 7'd10);
    return {tens, ones};
  endfunction

  function automatic logic [23:0] time_to_bcd(input time_t t);
    return {bcd2({1'b0, t.min}), bcd2({1'b0, t.sec}), bcd2(t.cs)};
  endfunction

endpackage

// File: rtl/btn_pulse.sv
// Button conditioner: 2-FF synchroniser plus rising-edge detector.
// A level already high when reset releases never produces a pulse.
module btn_pulse (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  logic       s1_q;
  logic       s2_q;
  logic       s3_q;
  logic [2:0] vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      vld_q <= 3'b000;
    end else begin
      s1_q  <= btn_i;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      vld_q <= {vld_q[1:0], 1'b1};
    end
  end

  // Edge only counts once s3 holds a real post-reset sample.
  assign pulse_o = s2_q & ~s3_q & vld_q[2];

endmodule

// File: rtl/lap_stopwatch.sv
// Centisecond stopwatch with start/stop, lap capture into a small slot
// memory, clear, and a BCD view of live time or one stored lap.
module lap_stopwatch
  import sw_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100,
  parameter int N_LAPS  = 4,
  parameter int LW      = $clog2(N_LAPS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ss_btn,
  input  logic          lap_btn,
  input  logic          clr_btn,
  input  logic [LW-1:0] sel,
  output logic          running,
  output logic [LW-1:0] lap_count,
  output logic          lap_full,
  output logic          overflow,
  output logic [23:0]   disp_bcd
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [2:0] btn_raw;
  logic [2:0] btn_p;
  logic       ss_p, lap_p, clr_p;

  assign btn_raw = {clr_btn, lap_btn, ss_btn};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      btn_pulse u_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_raw[gi]),
        .pulse_o (btn_p[gi])
      );
    end
  endgenerate

  assign ss_p  = btn_p[0];
  assign lap_p = btn_p[1];
  assign clr_p = btn_p[2];

  logic          running_q, running_d;
  logic [PW-1:0] pre_q, pre_d;
  time_t         time_q, time_d;
  logic          overflow_q, overflow_d;
  logic [LW-1:0] lap_cnt_q, lap_cnt_d;
  time_t         laps_q [N_LAPS];
  time_t         laps_d [N_LAPS];
  logic          tick;
  logic          full;

  assign tick = running_q && (pre_q == PRE_LAST);
  assign full = (lap_cnt_q == LW'(N_LAPS));

  // Lap and clear both look at running_q, so a same-cycle ss toggle acts after them.
  always_comb begin
    running_d  = running_q ^ ss_p;
    pre_d      = pre_q;
    time_d     = time_q;
    overflow_d = overflow_q;
    lap_cnt_d  = lap_cnt_q;
    laps_d     = laps_q;
    if (running_q) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        if (time_q.cs != MAX_CS) begin
          time_d.cs = time_q.cs + 7'd1;
        end else begin
          time_d.cs = '0;
          if (time_q.sec != MAX_SEC) begin
            time_d.sec = time_q.sec + 6'd1;
          end else begin
            time_d.sec = '0;
            if (time_q.min != MAX_MIN) begin
              time_d.min = time_q.min + 6'd1;
            end else begin
              time_d.min = '0;
              overflow_d = 1'b1;
            end
          end
        end
      end
      if (lap_p && !full) begin
        for (int k = 0; k < N_LAPS; k++) begin
          if (lap_cnt_q == LW'(k)) laps_d[k] = time_q;
        end
        lap_cnt_d = lap_cnt_q + LW'(1);
      end
    end else if (clr_p) begin
      pre_d      = '0;
      time_d     = '0;
      overflow_d = 1'b0;
      lap_cnt_d  = '0;
      laps_d     = '{default: '0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running_q  <= 1'b0;
      pre_q      <= '0;
      time_q     <= '0;
      overflow_q <= 1'b0;
      lap_cnt_q  <= '0;
      laps_q     <= '{default: '0};
    end else begin
      running_q  <= running_d;
      pre_q      <= pre_d;
      time_q     <= time_d;
      overflow_q <= overflow_d;
      lap_cnt_q  <= lap_cnt_d;
      laps_q     <= laps_d;
    end
  end

  time_t disp_time;

  always_comb begin
    disp_time = '0;
    if (sel == '0) begin
      disp_time = time_q;
    end else begin
      for (int k = 0; k < N_LAPS; k++) begin
        if (sel == LW'(k + 1) && LW'(k) < lap_cnt_q) disp_time = laps_q[k];
      end
    end
  end

  assign disp_bcd  = time_to_bcd(disp_time);
  assign running   = running_q;
  assign lap_count = lap_cnt_q;
  assign lap_full  = full;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch: stimulus queues expected values,
// a negedge monitor pops and compares them against the outputs.
module tb_lap_stopwatch;

  localparam int SS  = 1;
  localparam int LAP = 2;
  localparam int CLR = 4;

  localparam int W_DISP = 0;
  localparam int W_RUN  = 1;
  localparam int W_CNT  = 2;
  localparam int W_FULL = 3;
  localparam int W_OVF  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ss_btn = 1'b0;
  logic        lap_btn = 1'b0;
  logic        clr_btn = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic        running;
  logic [2:0]  lap_count;
  logic        lap_full;
  logic        overflow;
  logic [23:0] disp_bcd;

  lap_stopwatch #(.CLK_HZ(1000), .TICK_HZ(100), .N_LAPS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ss_btn    (ss_btn),
    .lap_btn   (lap_btn),
    .clr_btn   (clr_btn),
    .sel       (sel),
    .running   (running),
    .lap_count (lap_count),
    .lap_full  (lap_full),
    .overflow  (overflow),
    .disp_bcd  (disp_bcd)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          what;
    logic [23:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input int what, input logic [23:0] exp);
    sb_item_t it;
    it.name = name;
    it.what = what;
    it.exp  = exp;
    sb_q.push_back(it);
  endtask

  // Monitor: outputs are sampled on the falling edge, away from state updates.
  initial begin
    sb_item_t    it;
    logic [23:0] act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        case (it.what)
          W_DISP:  act = disp_bcd;
          W_RUN:   act = {23'd0, running};
          W_CNT:   act = {21'd0, lap_count};
          W_FULL:  act = {23'd0, lap_full};
          default: act = {23'd0, overflow};
        endcase
        n_tests++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %h, expected %h", it.name, cyc, act, it.exp);
        end else begin
          $display("ok   %s @cyc %0d: %h", it.name, cyc, act);
        end
      end
    end
  end

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic set_btns(input int mask, input logic v);
    if (mask[0]) ss_btn  = v;
    if (mask[1]) lap_btn = v;
    if (mask[2]) clr_btn = v;
  endtask

  // Pulse reaches the core on the third edge after 'at'.
  task automatic press(input int mask, input int at, input int hold);
    goto(at);
    set_btns(mask, 1'b1);
    goto(at + hold);
    set_btns(mask, 1'b0);
  endtask

  initial begin
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_disp", W_DISP, 24'h000000);
    chk("rst_run",  W_RUN,  24'd0);
    chk("rst_cnt",  W_CNT,  24'd0);
    chk("rst_full", W_FULL, 24'd0);
    chk("rst_ovf",  W_OVF,  24'd0);
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    cyc = 0;

    // Start: ss held 5 clk, running at edge 3, first tick 10 clk later.
    ss_btn = 1'b1;
    goto(2);   chk("start_pre",  W_RUN,  24'd0);
    goto(3);   chk("start_run",  W_RUN,  24'd1);
               chk("start_disp", W_DISP, 24'h000000);
    goto(5);   ss_btn = 1'b0;
    goto(12);  chk("pre_tick",   W_DISP, 24'h000000);
    goto(13);  chk("first_tick", W_DISP, 24'h000001);

    // Laps captured at cs 1,3,5,7; fifth ignored.
    press(LAP, 13, 2);
    goto(17);  chk("lap1_cnt", W_CNT, 24'd1);
    press(LAP, 33, 2);
    goto(37);  chk("lap2_cnt", W_CNT, 24'd2);
    press(LAP, 53, 2);
    goto(57);  chk("lap3_cnt", W_CNT, 24'd3);
               chk("lap3_nfull", W_FULL, 24'd0);
    press(LAP, 73, 2);
    goto(77);  chk("lap4_cnt",  W_CNT,  24'd4);
               chk("lap4_full", W_FULL, 24'd1);
    press(LAP, 93, 2);
    goto(97);  chk("lap5_cnt", W_CNT, 24'd4);
               sel = 3'd2; chk("sel2", W_DISP, 24'h000003);
    goto(98);  sel = 3'd0; chk("sel0_live", W_DISP, 24'h000009);
    goto(99);  sel = 3'd5; chk("sel5_zero", W_DISP, 24'h000000);
    goto(100); sel = 3'd4; chk("sel4", W_DISP, 24'h000007);
    goto(101); sel = 3'd7; chk("sel7_zero", W_DISP, 24'h000000);
    goto(102); sel = 3'd1; chk("sel1", W_DISP, 24'h000001);
    goto(103); sel = 3'd0;

    // Clear while running has no effect.
    press(CLR, 103, 2);
    goto(107); chk("clr_run_disp", W_DISP, 24'h000010);
               chk("clr_run_cnt",  W_CNT,  24'd4);
               chk("clr_run_run",  W_RUN,  24'd1);

    // Stop, hold, then clear.
    press(SS, 110, 2);
    goto(114); chk("stop_run",  W_RUN,  24'd0);
               chk("stop_disp", W_DISP, 24'h000011);
    goto(120); chk("stop_hold", W_DISP, 24'h000011);
    press(CLR, 120, 2);
    goto(124); chk("clr_disp", W_DISP, 24'h000000);
               chk("clr_cnt",  W_CNT,  24'd0);
               chk("clr_full", W_FULL, 24'd0);
               chk("clr_run",  W_RUN,  24'd0);

    // ss+lap together: stopped -> start, no lap; running -> lap then stop.
    press(SS | LAP, 130, 2);
    goto(134); chk("sl_stop_run", W_RUN, 24'd1);
               chk("sl_stop_cnt", W_CNT, 24'd0);
    press(SS | LAP, 150, 2);
    goto(154); chk("sl_run_run",  W_RUN,  24'd0);
               chk("sl_run_cnt",  W_CNT,  24'd1);
               chk("sl_run_live", W_DISP, 24'h000002);
    goto(155); sel = 3'd1; chk("sl_run_lap", W_DISP, 24'h000001);
    goto(156); sel = 3'd0;

    // Minute carry from 00:59.99.
    goto(160); force dut.time_q = {6'd0, 6'd59, 7'd99};
    goto(161); release dut.time_q;
    goto(162); chk("load_5999", W_DISP, 24'h005999);
    press(SS, 163, 2);
    goto(175); chk("min_pre",   W_DISP, 24'h005999);
    goto(176); chk("min_carry", W_DISP, 24'h010000);
               chk("min_novf",  W_OVF,  24'd0);
    press(SS, 177, 2);
    goto(181); chk("min_stop", W_DISP, 24'h010000);

    // Full wrap from 59:59.99; prescaler resumes from its held value.
    goto(182); force dut.time_q = {6'd59, 6'd59, 7'd99};
    goto(183); release dut.time_q;
    goto(184); chk("load_595999", W_DISP, 24'h595999);
    press(SS, 185, 2);
    goto(193); chk("wrap_pre",  W_DISP, 24'h595999);
               chk("wrap_novf", W_OVF,  24'd0);
    goto(194); chk("wrap_disp", W_DISP, 24'h000000);
               chk("wrap_ovf",  W_OVF,  24'd1);
    goto(200); chk("ovf_sticky", W_OVF, 24'd1);

    // Async reset mid-count with buttons held across release.
    goto(201); sel = 3'd1; lap_btn = 1'b1; ss_btn = 1'b1;
               chk("pre_rst_lap", W_DISP, 24'h000001);
    goto(202); rst = 1'b1;
               chk("arst_run",  W_RUN,  24'd0);
               chk("arst_cnt",  W_CNT,  24'd0);
               chk("arst_full", W_FULL, 24'd0);
               chk("arst_ovf",  W_OVF,  24'd0);
               chk("arst_disp", W_DISP, 24'h000000);
    goto(205); rst = 1'b0;
    goto(215); chk("held_run", W_RUN, 24'd0);
               chk("held_cnt", W_CNT, 24'd0);
               ss_btn = 1'b0; lap_btn = 1'b0; sel = 3'd0;

    // Buttons still work after reset.
    press(SS, 220, 2);
    goto(222); chk("post_pre", W_RUN, 24'd0);
    goto(223); chk("post_run", W_RUN, 24'd1);
    press(LAP, 230, 2);
    goto(234); chk("post_cnt",  W_CNT,  24'd1);
               chk("post_disp", W_DISP, 24'h000001);

    goto(cyc + 3);
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending checks, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
